// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file scan reader.
package regfile_pkg;

  localparam int REGFILE_ADDR_W = 3;
  localparam int REGFILE_DATA_W = 16;
  localparam int SETTLE_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HOLD,
    DONE
  } scan_state_t;

endpackage

// File: rtl/regfile_scan_reader_scan_addr_gen.sv
// R/S read-address counters: R walks 0..2^ADDR_W-1, S tracks R plus a fixed offset.
module scan_addr_gen #(
  parameter int ADDR_W = 3,
  parameter int OFFSET = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] r_adr,
  output logic [ADDR_W-1:0] s_adr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] S_START = ADDR_W'(OFFSET % (1 << ADDR_W));

  logic [ADDR_W-1:0] r_adr_q, r_adr_d;
  logic [ADDR_W-1:0] s_adr_q, s_adr_d;

  // Both counters wrap naturally at the address width.
  always_comb begin
    r_adr_d = r_adr_q;
    s_adr_d = s_adr_q;
    if (load) begin
      r_adr_d = '0;
      s_adr_d = S_START;
    end else if (inc) begin
      r_adr_d = r_adr_q + 1'b1;
      s_adr_d = s_adr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_adr_q <= '0;
      s_adr_q <= '0;
    end else begin
      r_adr_q <= r_adr_d;
      s_adr_q <= s_adr_d;
    end
  end

  assign r_adr = r_adr_q;
  assign s_adr = s_adr_q;
  assign last  = &r_adr_q;

endmodule

// File: rtl/regfile_scan_reader.sv
// Walks every register-file address, captures R/S read data and streams the pairs out.
// Optional running XOR of captured data: define REGFILE_SCAN_CHECKSUM_EN.
module regfile_scan_reader
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int S_OFFSET = 4,
  parameter int SETTLE   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] R_Adr,
  output logic [ADDR_W-1:0] S_Adr,
  input  logic [DATA_W-1:0] R,
  input  logic [DATA_W-1:0] S,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_s,
  output logic              busy,
  output logic              done
`ifdef REGFILE_SCAN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE - 1);

  scan_state_t state_q, state_d;

  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]       out_idx_q, out_idx_d;
  logic [DATA_W-1:0]       out_r_q, out_r_d;
  logic [DATA_W-1:0]       out_s_q, out_s_d;

  logic addr_load;
  logic addr_inc;
  logic capture;
  logic handshake;
  logic last_entry;

  scan_addr_gen #(
    .ADDR_W (ADDR_W),
    .OFFSET (S_OFFSET)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .load  (addr_load),
    .inc   (addr_inc),
    .r_adr (R_Adr),
    .s_adr (S_Adr),
    .last  (last_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (cnt_q == '0) state_d = HOLD;
      HOLD:    if (out_valid_q && out_ready) state_d = last_entry ? DONE : SETUP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    handshake = out_valid_q && out_ready;
    addr_load = (state_q == IDLE) && start;
    addr_inc  = (state_q == HOLD) && handshake && !last_entry;
    capture   = (state_q == SETUP) && (cnt_q == '0);
  end

  // Settle counter reloads whenever a new address is presented to the register file.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_r_d     = out_r_q;
    out_s_d     = out_s_q;
    if (addr_load || addr_inc) begin
      cnt_d = SETTLE_LOAD;
    end else if ((state_q == SETUP) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (capture) begin
      out_valid_d = 1'b1;
      out_idx_d   = R_Adr;
      out_r_d     = R;
      out_s_d     = S;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_r_q     <= '0;
      out_s_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_r_q     <= out_r_d;
      out_s_q     <= out_s_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_r     = out_r_q;
  assign out_s     = out_s_q;

`ifdef REGFILE_SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (addr_load) begin
      checksum_d = '0;
    end else if (capture) begin
      checksum_d = checksum_q ^ R ^ S;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
